// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for the sequential ALU.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_ADD = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_SAR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_LUI = 4'b1111;

    localparam int FLG_C = 0;
    localparam int FLG_L = 2;
    localparam int FLG_V = 5;
    localparam int FLG_Z = 6;
    localparam int FLG_N = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle,
// done pulses for one cycle after the last of WIDTH steps.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   psum;

    // Upper half accumulates the multiplicand; lower half holds the unused multiplier bits.
    assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            prod  <= '0;
            mcand <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                prod  <= {{WIDTH{1'b0}}, b};
                mcand <= a;
                cnt   <= '0;
                run   <= 1'b1;
            end else if (run) begin
                prod <= {psum, prod[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with held results and flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (opcode 1000).
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic [15:0]      flags
);

    localparam int SHW = $clog2(WIDTH);

    state_t                  state;
    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          sum_c;
    logic [WIDTH:0]          dif_c;
    logic [WIDTH:0]          shl_c;
    logic [WIDTH:0]          shr_c;
    logic signed [WIDTH:0]   sar_c;
    logic [WIDTH-1:0]        y_c;
    logic [15:0]             f_c;

    assign sh = b[SHW-1:0];

`ifdef ALU_SEQ_MUL_EN
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    assign mul_start = (state == IDLE) && in_valid && (sel == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`endif

    // Shifts run one bit wider so the last bit shifted out lands in the spare position.
    always_comb begin
        sum_c = {1'b0, a} + {1'b0, b};
        dif_c = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        shl_c = {1'b0, a} << sh;
        shr_c = {a, 1'b0} >> sh;
        sar_c = $signed({a, 1'b0}) >>> sh;
        y_c   = a;
        f_c   = '0;
        case (sel)
            OP_AND: y_c = a & b;
            OP_OR:  y_c = a | b;
            OP_XOR: y_c = a ^ b;
            OP_MOV: y_c = b;
            OP_LUI: y_c = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_ADD: begin
                y_c        = sum_c[WIDTH-1:0];
                f_c[FLG_C] = sum_c[WIDTH];
                f_c[FLG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y_c        = dif_c[WIDTH-1:0];
                f_c[FLG_C] = dif_c[WIDTH];
                f_c[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (dif_c[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                f_c[FLG_C] = dif_c[WIDTH];
                f_c[FLG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (dif_c[WIDTH-1] != a[WIDTH-1]);
                f_c[FLG_L] = (a < b);
                f_c[FLG_Z] = (dif_c[WIDTH-1:0] == '0);
                f_c[FLG_N] = dif_c[WIDTH-1];
            end
            OP_SHL: begin
                y_c        = shl_c[WIDTH-1:0];
                f_c[FLG_C] = shl_c[WIDTH];
            end
            OP_SHR: begin
                y_c        = shr_c[WIDTH:1];
                f_c[FLG_C] = shr_c[0];
            end
            OP_SAR: begin
                y_c        = sar_c[WIDTH:1];
                f_c[FLG_C] = sar_c[0];
            end
            default: y_c = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= '0;
            y_hi      <= '0;
            flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                        if (sel == OP_MUL) begin
                            state <= BUSY;
                        end else
`endif
                        begin
                            y         <= y_c;
                            y_hi      <= '0;
                            flags     <= f_c;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
`ifdef ALU_SEQ_MUL_EN
                    if (mul_done) begin
                        y            <= mul_prod[WIDTH-1:0];
                        y_hi         <= mul_prod[2*WIDTH-1:WIDTH];
                        flags        <= '0;
                        flags[FLG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
`else
                    state    <= IDLE;
                    in_ready <= 1'b1;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=16) against a behavioural model.
module tb_alu_seq;
    import alu_seq_pkg::*;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic [15:0] y_hi;
    logic [15:0] flags;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Reference result {y, y_hi, flags} from plain integer arithmetic.
    function automatic logic [47:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] z);
        int          ua = int'(x);
        int          ub = int'(z);
        int          sa = int'($signed(x));
        int          sb = int'($signed(z));
        int          n  = int'(z[3:0]);
        int          r;
        longint      p;
        logic [15:0] ry = x;
        logic [15:0] rh = 16'h0;
        logic [15:0] f  = 16'h0;
        logic [15:0] d;
        case (op)
            4'b0001: ry = x & z;
            4'b0010: ry = x | z;
            4'b0011: ry = x ^ z;
            4'b1101: ry = z;
            4'b1111: ry = {z[7:0], 8'h00};
            4'b0101: begin
                r = ua + ub; ry = r[15:0]; f[0] = (r > 65535);
                r = sa + sb; f[5] = (r > 32767) || (r < -32768);
            end
            4'b1001: begin
                ry = x - z; f[0] = (ua >= ub);
                r = sa - sb; f[5] = (r > 32767) || (r < -32768);
            end
            4'b1011: begin
                d = x - z; f[0] = (ua >= ub);
                r = sa - sb; f[5] = (r > 32767) || (r < -32768);
                f[2] = (ua < ub); f[6] = (ua == ub); f[7] = d[15];
            end
            4'b0100: begin ry = x << n; f[0] = (n == 0) ? 1'b0 : x[16-n]; end
            4'b0110: begin ry = x >> n; f[0] = (n == 0) ? 1'b0 : x[n-1]; end
            4'b0111: begin ry = $signed(x) >>> n; f[0] = (n == 0) ? 1'b0 : x[n-1]; end
            4'b1000: begin
                if (MUL_EN) begin
                    p = longint'(ua) * longint'(ub);
                    ry = p[15:0]; rh = p[31:16]; f[0] = (rh != 0);
                end
            end
            default: ry = x;
        endcase
        return {ry, rh, f};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [15:0] ai, input logic [15:0] bi,
                          output logic [47:0] res, output int lat, output bit rdy_ok, output bit busy_rdy);
        @(negedge clk);
        sel = op; a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
        rdy_ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sel = 4'($urandom);
        busy_rdy = in_ready;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid) busy_rdy |= in_ready;
        end while (!out_valid && lat < 100);
        res = {y, y_hi, flags};
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if ({y, y_hi, flags} !== 48'h0) begin failures++; $display("FAIL reset_outputs: got %h want 0", {y, y_hi, flags}); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0]  ops [9] = '{OP_ADD, OP_CMP, OP_CMP, OP_SAR, OP_SHL, OP_SUB, OP_LUI, OP_SHR, OP_AND};
        logic [15:0] as  [9] = '{16'h7FFF, 16'h0003, 16'h1234, 16'h8001, 16'h1234, 16'h8000, 16'h5555, 16'h00F0, 16'hF0F0};
        logic [15:0] bs  [9] = '{16'h0001, 16'h0005, 16'h1234, 16'h0001, 16'h0010, 16'h0001, 16'h12AB, 16'h0005, 16'h3C3C};
        logic [47:0] ex  [9] = '{48'h8000_0000_0020, 48'h0003_0000_0084, 48'h1234_0000_0041,
                                 48'hC000_0000_0001, 48'h1234_0000_0000, 48'h7FFF_0000_0021,
                                 48'hAB00_0000_0000, 48'h0007_0000_0001, 48'h3030_0000_0000};
        logic [47:0] res;
        int          lat;
        bit          rok, brdy;
        for (int i = 0; i < 9; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, rok, brdy);
            checks++; if (res !== ex[i]) begin failures++; $display("FAIL directed_%0d result: got %h want %h", i, res, ex[i]); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL directed_%0d latency: got %0d want 1", i, lat); end
            checks++; if (rok !== 1'b1) begin failures++; $display("FAIL directed_%0d in_ready: got %b want 1", i, rok); end
        end
    endtask

    task automatic test_mul_or_default();
        logic [47:0] res;
        int          lat;
        bit          rok, brdy;
        if (MUL_EN) begin
            run_op(OP_MUL, 16'h1234, 16'h0010, res, lat, rok, brdy);
            checks++; if (res !== 48'h2340_0001_0001) begin failures++; $display("FAIL mul_result: got %h want 234000010001", res); end
            checks++; if (lat !== 17) begin failures++; $display("FAIL mul_latency: got %0d want 17", lat); end
            checks++; if (brdy !== 1'b0) begin failures++; $display("FAIL mul_in_ready_busy: got %b want 0", brdy); end
        end else begin
            run_op(OP_MUL, 16'hABCD, 16'h1234, res, lat, rok, brdy);
            checks++; if (res !== 48'hABCD_0000_0000) begin failures++; $display("FAIL default_op_result: got %h want abcd00000000", res); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL default_op_latency: got %0d want 1", lat); end
        end
    endtask

    task automatic test_random();
        logic [47:0] res, exp;
        logic [3:0]  op;
        logic [15:0] ra, rb;
        int          lat, elat;
        bit          rok, brdy;
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            if (i % 7 == 0) rb = ra;
            exp  = model(op, ra, rb);
            elat = (MUL_EN && op == OP_MUL) ? 17 : 1;
            run_op(op, ra, rb, res, lat, rok, brdy);
            checks++; if (res !== exp) begin failures++; $display("FAIL random_%0d op=%h a=%h b=%h: got %h want %h", i, op, ra, rb, res, exp); end
            checks++; if (lat !== elat) begin failures++; $display("FAIL random_%0d latency: got %0d want %0d", i, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] held;
        @(negedge clk);
        sel = OP_ADD; a = 16'h0001; b = 16'h0002; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        sel = OP_XOR; a = 16'h0005; b = 16'h0003;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_rise: got %b want 1", out_valid); end
        held = {y, y_hi, flags};
        checks++; if (held !== 48'h0003_0000_0000) begin failures++; $display("FAIL bp_result: got %h want 000300000000", held); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready, y, y_hi, flags} !== {2'b10, held}) begin
                failures++; $display("FAIL bp_hold_%0d: got %b%b %h want 10 %h", i, out_valid, in_ready, {y, y_hi, flags}, held);
            end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin failures++; $display("FAIL bp_release: got %b%b want 01", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if ({out_valid, y} !== {1'b1, 16'h0006}) begin failures++; $display("FAIL bp_pending_op: got %b %h want 1 0006", out_valid, y); end
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [47:0] q[$];
        logic [47:0] exp;
        int          accepts = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin failures++; $display("FAIL b2b_unexpected: got %h want none", {y, y_hi, flags}); end
                else begin
                    exp = q.pop_front();
                    if ({y, y_hi, flags} !== exp) begin failures++; $display("FAIL b2b_result: got %h want %h", {y, y_hi, flags}, exp); end
                end
            end
            if (cyc < 20) begin
                sel = 4'($urandom_range(0, 15));
                if (sel == OP_MUL) sel = OP_ADD;
                a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
                if (in_ready) begin q.push_back(model(sel, a, b)); accepts++; end
            end else begin
                in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        checks++; if (accepts !== 10) begin failures++; $display("FAIL b2b_throughput: got %0d accepts want 10", accepts); end
        checks++; if (q.size() !== 0) begin failures++; $display("FAIL b2b_drain: got %0d left want 0", q.size()); end
    endtask

    task automatic test_reset_abort();
        bit seen;
        if (MUL_EN) begin
            @(negedge clk); sel = OP_MUL; a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b0;
            @(posedge clk); #1; in_valid = 1'b0;
            repeat (8) @(posedge clk);
            @(negedge clk); rst = 1'b1;
            @(posedge clk); #1;
            checks++; if ({in_ready, out_valid, y, y_hi, flags} !== {2'b10, 48'h0}) begin
                failures++; $display("FAIL mul_abort: got %b%b %h want 10 0", in_ready, out_valid, {y, y_hi, flags});
            end
            @(negedge clk); rst = 1'b0;
            seen = 1'b0;
            repeat (25) begin @(posedge clk); #1; seen |= out_valid; end
            checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mul_abort_ghost: got out_valid %b want 0", seen); end
        end
        @(negedge clk); sel = OP_ADD; a = 16'h1111; b = 16'h2222; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checks++; if ({out_valid, y} !== {1'b1, 16'h3333}) begin failures++; $display("FAIL done_pre_abort: got %b %h want 1 3333", out_valid, y); end
        @(negedge clk); rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid, y, y_hi, flags} !== {2'b10, 48'h0}) begin
            failures++; $display("FAIL done_abort: got %b%b %h want 10 0", in_ready, out_valid, {y, y_hi, flags});
        end
        @(posedge clk); #1;
        checks++; if ({in_ready, out_valid, y} !== {2'b10, 16'h0}) begin
            failures++; $display("FAIL rst_priority: got %b%b %h want 10 0", in_ready, out_valid, y);
        end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        seen = 1'b0;
        repeat (5) begin @(posedge clk); #1; seen |= out_valid; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL done_abort_ghost: got out_valid %b want 0", seen); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mul_or_default();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 16-bit combinational datapath ALU. It registers operands on a valid/ready handshake, executes the existing opcode set at `WIDTH` bits, and adds shifts and an iterative multiplier. It holds each result and its flags until the consumer accepts them. It sits between the register-file read stage and the write-back stage, so multi-cycle operations stall issue instead of stretching the clock.

## Interface
- `WIDTH`, default 16: datapath width; even, ≥8.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, not overridden.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operands and `sel` are valid.
- `in_ready` out 1: block can accept an operation.
- `a`, `b` in `WIDTH`: operands.
- `sel` in 4: opcode.
- `out_valid` out 1: `y`, `y_hi` and `flags` are valid.
- `out_ready` in 1: consumer accepts the result.
- `y` out `WIDTH`: result.
- `y_hi` out `WIDTH`: upper half of the MUL product; 0 for all other ops.
- `flags` out 16: bit 0 carry, bit 2 low, bit 5 overflow, bit 6 zero, bit 7 negative; all other bits 0.

## Operation
- Opcodes 0001 AND, 0010 OR, 0011 XOR, 0101 ADD, 1001 SUB, 1011 CMP and 1101 MOV keep their existing meaning.
- LUI (1111): `y = {b[WIDTH/2-1:0], WIDTH/2 zeros}`.
- New: 0100 SHL, 0110 SHR (logical), 0111 SAR (arithmetic), 1000 MUL (unsigned).
- Shift amount is `b[SHW-1:0]`.
- Every other opcode is a default op: `y = a`, flags 0.
- ADD/SUB:
  - Arithmetic is done on `WIDTH+1` bits; bit `WIDTH` is the carry.
  - SUB is computed as `a + ~b + 1`.
  - Overflow uses the signed rules: ADD sets it when the operand signs are equal and differ from the result sign; SUB sets it when the operand signs differ and the result sign differs from `a`.
- CMP:
  - Computes SUB internally.
  - Low = unsigned `a < b`; zero = difference is 0; negative = difference MSB; carry and overflow as for SUB.
  - `y = a`.
- Low, zero and negative are set by CMP only.
- Carry and overflow are set by ADD/SUB/CMP only, except:
  - Shifts: carry = last bit shifted out; 0 when the shift amount is 0.
  - MUL: carry = `|y_hi`.
- FSM states:
  - IDLE: `in_ready=1`.
    - `in_valid` with a non-MUL op → compute, register the result → DONE.
    - `in_valid` with MUL → latch the operands, clear the counter → BUSY.
  - BUSY: one shift-add step per cycle; counter counts 0..`WIDTH-1`; after step `WIDTH-1` → DONE.
  - DONE: `out_valid=1`; outputs held stable; `out_ready` → IDLE.
- `in_ready` is high only in IDLE. An operation offered in DONE waits; there is no same-cycle accept-while-draining.
- Inputs are sampled only on the accept edge; later changes to `a`, `b` or `sel` have no effect on an operation in flight.

## Timing
- Reset: state IDLE; `in_ready=1`; `out_valid=0`; `y`, `y_hi`, `flags` and the counter all 0.
- `rst` asserted mid-MUL or in DONE aborts the operation; the result is discarded and never presented.
- Single-cycle ops: accept at edge k → `out_valid` high after edge k+1.
- MUL: accept at edge k → `out_valid` after edge k+`WIDTH`+1 (17 for `WIDTH=16`).
- Throughput with `out_ready` tied high: one single-cycle op every 2 cycles.
- `out_valid` and the result are held indefinitely until `out_ready`. A held result never changes.
- `rst` has priority over every handshake in the same cycle.

## Configuration
- `ALU_SEQ_MUL_EN`:
  - Defined: MUL (1000) is implemented as above, together with the BUSY state and the counter.
  - Undefined: 1000 is a default op (single-cycle, `y = a`, `y_hi = 0`, flags 0); the multiplier sub-module is not instantiated.

## Structure
- Package `alu_seq_pkg` holds:
  - opcode localparams `OP_AND` … `OP_MUL`;
  - flag bit indices `FLG_C=0`, `FLG_L=2`, `FLG_V=5`, `FLG_Z=6`, `FLG_N=7`;
  - the FSM state type (IDLE, BUSY, DONE).
- Sub-module `alu_seq_mul`:
  - iterative shift-add multiplier, parameterised by `WIDTH`;
  - ports `start`, `a`, `b`, `done`, `prod[2*WIDTH-1:0]`;
  - `done` pulses once, at the end of step `WIDTH-1`.

## Test plan
All scenarios use `WIDTH=16`.
- ADD 0x7FFF+0x0001 → `y=0x8000`, flags V=1, C=0, Z=N=L=0; `out_valid` one cycle after accept.
- CMP `a=0x0003`, `b=0x0005` → `y=0x0003`; L=1, N=1, C=0, Z=0. CMP 0x1234,0x1234 → Z=1, C=1.
- SAR `a=0x8001`, `b=0x0001` → `y=0xC000`, C=1. SHL by 0 → `y=a`, C=0.
- MUL 0x1234×0x0010 → `y=0x2340`, `y_hi=0x0001`, C=1; `out_valid` 17 cycles after accept; `in_ready=0` throughout.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE → outputs stable, `in_ready=0`; release → IDLE next cycle.
- Assert `rst` at BUSY step 8 → next cycle IDLE, `out_valid=0`, all outputs 0. Without `ALU_SEQ_MUL_EN`, `sel=1000`, `a=0xABCD` → `y=0xABCD`, flags 0, single-cycle.
